// File: rtl/sobel_pkg.sv
// Shared definitions for the sobel core and its frame controller: FSM encoding,
// window/feed lengths, kernel constants and window index helpers.
package sobel_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_FEED  = 3'd2,
      S_WAIT  = 3'd3,
      S_WRITE = 3'd4,
      S_DONE  = 3'd5
   } ctrl_state_t;

   localparam int FEED_LEN = 10;
   localparam int WIN_N    = 9;
   localparam int PIX_MAX  = 255;

   // Row-major 3x3 kernels, index = 3*row + col.
   localparam int GX_K [WIN_N] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
   localparam int GY_K [WIN_N] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

   function automatic logic [1:0] win_row(input logic [3:0] k);
      return 2'(k / 4'd3);
   endfunction

   function automatic logic [1:0] win_col(input logic [3:0] k);
      return 2'(k % 4'd3);
   endfunction

endpackage

// File: rtl/sobel_win_addr_gen.sv
// Maps the current window centre (x, y) and window tap k to the image RAM read
// address and the output RAM write address for that centre.
module sobel_win_addr_gen #(
   parameter int IMG_W   = 64,
   parameter int ADDR_W  = 12,
   parameter int OADDR_W = 12,
   parameter int XW      = 6,
   parameter int YW      = 6
) (
   input  logic [XW-1:0]      i_x,
   input  logic [YW-1:0]      i_y,
   input  logic [3:0]         i_k,
   output logic [ADDR_W-1:0]  o_img_addr,
   output logic [OADDR_W-1:0] o_out_addr
);
   import sobel_pkg::*;

   logic [1:0] w_r;
   logic [1:0] w_c;

   assign w_r = win_row(i_k);
   assign w_c = win_col(i_k);

   // Centre is never on the border, so y+r-1 and x+c-1 stay non-negative.
   assign o_img_addr = (ADDR_W'(i_y) + ADDR_W'(w_r) - ADDR_W'(1)) * ADDR_W'(IMG_W)
                     + ADDR_W'(i_x) + ADDR_W'(w_c) - ADDR_W'(1);

   assign o_out_addr = (OADDR_W'(i_y) - OADDR_W'(1)) * OADDR_W'(IMG_W - 2)
                     + OADDR_W'(i_x) - OADDR_W'(1);

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame scheduler: walks interior pixels, fetches each 3x3 window, feeds the sobel
// core and stores its result. SOBEL_CTRL_WIN_REUSE_EN enables column-shift reuse.
module sobel_frame_ctrl #(
   parameter int IMG_W   = 64,
   parameter int IMG_H   = 64,
   parameter int ADDR_W  = 12,
   parameter int OADDR_W = 12
) (
   input  logic               clk_i_s,
   input  logic               rstn_i_s,
   input  logic               start_i,
   output logic               busy_o,
   output logic               frame_done_o,
   output logic [ADDR_W-1:0]  img_addr_o,
   output logic               img_rd_o,
   input  logic [7:0]         img_data_i,
   output logic               sob_en_o,
   output logic [7:0]         sob_data_o,
   input  logic [7:0]         sob_data_i,
   input  logic               sob_done_i,
   output logic               out_we_o,
   output logic [OADDR_W-1:0] out_addr_o,
   output logic [7:0]         out_data_o
);
   import sobel_pkg::*;

   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);

   ctrl_state_t        r_state;
   ctrl_state_t        w_nstate;
   logic [3:0]         r_cnt;
   logic [XW-1:0]      r_x;
   logic [YW-1:0]      r_y;
   logic [7:0]         r_win [WIN_N];

   logic               w_reuse;
   logic [3:0]         w_rds;
   logic [3:0]         w_k;
   logic [3:0]         w_cap_idx;
   logic [3:0]         w_feed_idx;
   logic               w_last_x;
   logic               w_last_y;
   logic [ADDR_W-1:0]  w_img_addr;
   logic [OADDR_W-1:0] w_out_addr;

`ifdef SOBEL_CTRL_WIN_REUSE_EN
   assign w_reuse = (r_x != XW'(1));
`else
   assign w_reuse = 1'b0;
`endif

   // With reuse only column 2 is fetched: taps 2, 5, 8.
   assign w_rds      = w_reuse ? 4'd3 : 4'(WIN_N);
   assign w_k        = w_reuse ? (r_cnt * 4'd3 + 4'd2) : r_cnt;
   assign w_cap_idx  = w_reuse ? ((r_cnt - 4'd1) * 4'd3 + 4'd2) : (r_cnt - 4'd1);
   assign w_feed_idx = r_cnt - 4'd1;
   assign w_last_x   = (r_x == XW'(IMG_W - 2));
   assign w_last_y   = (r_y == YW'(IMG_H - 2));

   sobel_win_addr_gen #(
      .IMG_W   (IMG_W),
      .ADDR_W  (ADDR_W),
      .OADDR_W (OADDR_W),
      .XW      (XW),
      .YW      (YW)
   ) u_addr_gen (
      .i_x        (r_x),
      .i_y        (r_y),
      .i_k        (w_k),
      .o_img_addr (w_img_addr),
      .o_out_addr (w_out_addr)
   );

   always_ff @(posedge clk_i_s or negedge rstn_i_s) begin
      if (!rstn_i_s) r_state <= S_IDLE;
      else           r_state <= w_nstate;
   end

   // All outputs decode from state, so an async reset clears them at once.
   always_comb begin
      w_nstate     = r_state;
      busy_o       = (r_state != S_IDLE);
      frame_done_o = 1'b0;
      img_rd_o     = 1'b0;
      img_addr_o   = '0;
      sob_en_o     = 1'b0;
      sob_data_o   = '0;
      out_we_o     = 1'b0;
      out_addr_o   = '0;
      out_data_o   = '0;
      case (r_state)
         S_IDLE: begin
            if (start_i) w_nstate = S_FETCH;
         end
         S_FETCH: begin
            if (r_cnt < w_rds) begin
               img_rd_o   = 1'b1;
               img_addr_o = w_img_addr;
            end
            if (r_cnt == w_rds) w_nstate = S_FEED;
         end
         S_FEED: begin
            sob_en_o   = 1'b1;
            sob_data_o = (r_cnt == 4'd0) ? 8'd0 : r_win[w_feed_idx];
            if (r_cnt == 4'(FEED_LEN - 1)) w_nstate = S_WAIT;
         end
         S_WAIT: begin
            // Dropping enable with done parks the core in INIT until the next feed.
            sob_en_o = ~sob_done_i;
            if (sob_done_i) w_nstate = S_WRITE;
         end
         S_WRITE: begin
            out_we_o   = 1'b1;
            out_addr_o = w_out_addr;
            out_data_o = sob_data_i;
            w_nstate   = (w_last_x && w_last_y) ? S_DONE : S_FETCH;
         end
         S_DONE: begin
            frame_done_o = 1'b1;
            w_nstate     = S_IDLE;
         end
         default: w_nstate = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i_s or negedge rstn_i_s) begin
      if (!rstn_i_s) begin
         r_cnt <= '0;
         r_x   <= XW'(1);
         r_y   <= YW'(1);
         for (int i = 0; i < WIN_N; i++) r_win[i] <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_cnt <= '0;
                  r_x   <= XW'(1);
                  r_y   <= YW'(1);
               end
            end
            S_FETCH: begin
               r_cnt <= (r_cnt == w_rds) ? 4'd0 : r_cnt + 4'd1;
`ifdef SOBEL_CTRL_WIN_REUSE_EN
               if (w_reuse && r_cnt == 4'd0) begin
                  for (int r = 0; r < 3; r++) begin
                     r_win[3*r]   <= r_win[3*r+1];
                     r_win[3*r+1] <= r_win[3*r+2];
                  end
               end
`endif
               // Read data lags the strobe by one cycle.
               if (r_cnt != 4'd0) r_win[w_cap_idx] <= img_data_i;
            end
            S_FEED: begin
               r_cnt <= (r_cnt == 4'(FEED_LEN - 1)) ? 4'd0 : r_cnt + 4'd1;
            end
            S_WRITE: begin
               r_cnt <= '0;
               if (w_last_x) begin
                  r_x <= XW'(1);
                  r_y <= r_y + YW'(1);
               end else begin
                  r_x <= r_x + XW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
